banked_sync_ram: RTL and testbench

BANKED_SYNC_RAM -- requirements
Module: banked_sync_ram

---
 rtl/banked_sync_ram_pkg.sv | 25 ++
 rtl/banked_sync_ram_bank.sv | 39 +++
 rtl/banked_sync_ram.sv | 170 +++++++++++++++++
 tb/tb_banked_sync_ram.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/banked_sync_ram_pkg.sv
// Shared types and helpers for banked_sync_ram: FSM state encoding,
// geometry derivations and the per-lane even-parity function.
package banked_sync_ram_pkg;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_e;

    // Widest lane the parity helper accepts; narrower lanes are zero-extended.
    localparam int PARITY_MAX_W = 64;

    function automatic int calc_lanes(input int data_width, input int lane_width);
        return data_width / lane_width;
    endfunction

    function automatic int calc_bank_sel_w(input int num_banks);
        return $clog2(num_banks);
    endfunction

    function automatic logic lane_parity(input logic [PARITY_MAX_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/banked_sync_ram_bank.sv
// ram_bank: single-port synchronous RAM with per-lane write enables and a
// registered read port; each lane is its own array so it maps to block RAM.
module ram_bank
    import banked_sync_ram_pkg::*;
#(
    parameter int IDX_W  = 11,
    parameter int LANES  = 2,
    parameter int LANE_W = 8
) (
    input  logic                    clk,
    input  logic                    en,
    input  logic                    we,
    input  logic [LANES-1:0]        lane_we,
    input  logic [IDX_W-1:0]        addr,
    input  logic [LANES*LANE_W-1:0] wdata,
    output logic [LANES*LANE_W-1:0] rdata
);

    localparam int DEPTH = 1 << IDX_W;

    genvar gi;
    for (gi = 0; gi < LANES; gi++) begin : gen_lane
        logic [LANE_W-1:0] mem_q [DEPTH];
        logic [LANE_W-1:0] rdata_q;

        // The read register only updates on reads, so it holds between them.
        always_ff @(posedge clk) begin
            if (en && we && lane_we[gi]) begin
                mem_q[addr] <= wdata[gi*LANE_W +: LANE_W];
            end
            if (en && !we) begin
                rdata_q <= mem_q[addr];
            end
        end

        assign rdata[gi*LANE_W +: LANE_W] = rdata_q;
    end

endmodule

// File: rtl/banked_sync_ram.sv
// Banked single-port RAM with self-clearing INIT sequence and lane write enables.
// Optional per-lane even parity enabled by defining BANKED_SYNC_RAM_PARITY_EN.
module banked_sync_ram
    import banked_sync_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16,
    parameter int NUM_BANKS  = 2,
    parameter int LANE_WIDTH = 8
) (
    input  logic                                               clk,
    input  logic                                               rst_n,
    input  logic                                               req_valid,
    output logic                                               req_ready,
    input  logic                                               req_we,
    input  logic [ADDR_WIDTH-1:0]                              req_addr,
    input  logic [DATA_WIDTH-1:0]                              req_wdata,
    input  logic [calc_lanes(DATA_WIDTH, LANE_WIDTH)-1:0]      req_lane_en,
    output logic                                               rsp_valid,
    output logic [DATA_WIDTH-1:0]                              rsp_rdata,
    output logic                                               init_done,
    output logic [calc_lanes(DATA_WIDTH, LANE_WIDTH)-1:0]      parity_err
);

    localparam int LANES = calc_lanes(DATA_WIDTH, LANE_WIDTH);
    localparam int BSW   = calc_bank_sel_w(NUM_BANKS);
    localparam int IDX_W = ADDR_WIDTH - BSW;
    localparam int DEPTH = 1 << IDX_W;
`ifdef BANKED_SYNC_RAM_PARITY_EN
    localparam int STORE_W = LANE_WIDTH + 1;
`else
    localparam int STORE_W = LANE_WIDTH;
`endif
    localparam int ROW_W = STORE_W * LANES;

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      init_cnt_q, init_cnt_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [BSW-1:0]        rd_bank_q, rd_bank_d;
    logic [DATA_WIDTH-1:0] rdata_hold_q, rdata_hold_d;

    logic                  ready;
    logic                  req_fire;
    logic [BSW-1:0]        req_bank;
    logic [IDX_W-1:0]      req_idx;

    logic [NUM_BANKS-1:0]  bank_en;
    logic                  bank_we;
    logic [LANES-1:0]      bank_lane_we;
    logic [IDX_W-1:0]      bank_addr;
    logic [ROW_W-1:0]      bank_wdata;
    logic [ROW_W-1:0]      bank_rdata [NUM_BANKS];

    logic [ROW_W-1:0]      wr_row;
    logic [ROW_W-1:0]      sel_row;
    logic [DATA_WIDTH-1:0] sel_data;
`ifdef BANKED_SYNC_RAM_PARITY_EN
    logic [LANES-1:0]      sel_perr;
`endif

    assign req_bank = req_addr[ADDR_WIDTH-1 -: BSW];
    assign req_idx  = req_addr[IDX_W-1:0];
    assign req_fire = req_valid && ready;

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        ready      = 1'b0;
        case (state_q)
            ST_INIT: begin
                init_cnt_d = init_cnt_q + IDX_W'(1);
                if (init_cnt_q == IDX_W'(DEPTH - 1)) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                ready = 1'b1;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    assign req_ready = ready;
    assign init_done = ready;

    // INIT drives every bank at once with a zero row (zero has even parity 0).
    always_comb begin
        bank_en      = '0;
        bank_we      = 1'b0;
        bank_lane_we = '0;
        bank_addr    = req_idx;
        bank_wdata   = wr_row;
        rsp_valid_d  = 1'b0;
        rd_bank_d    = rd_bank_q;
        if (state_q == ST_INIT) begin
            bank_en      = '1;
            bank_we      = 1'b1;
            bank_lane_we = '1;
            bank_addr    = init_cnt_q;
            bank_wdata   = '0;
        end else if (req_fire) begin
            bank_en[req_bank] = 1'b1;
            bank_we           = req_we;
            bank_lane_we      = req_lane_en;
            if (!req_we) begin
                rsp_valid_d = 1'b1;
                rd_bank_d   = req_bank;
            end
        end
    end

    genvar gi;
    for (gi = 0; gi < LANES; gi++) begin : gen_lane
        assign wr_row[gi*STORE_W +: LANE_WIDTH]     = req_wdata[gi*LANE_WIDTH +: LANE_WIDTH];
        assign sel_data[gi*LANE_WIDTH +: LANE_WIDTH] = sel_row[gi*STORE_W +: LANE_WIDTH];
`ifdef BANKED_SYNC_RAM_PARITY_EN
        assign wr_row[gi*STORE_W + LANE_WIDTH] =
            lane_parity(PARITY_MAX_W'(req_wdata[gi*LANE_WIDTH +: LANE_WIDTH]));
        assign sel_perr[gi] = sel_row[gi*STORE_W + LANE_WIDTH] ^
            lane_parity(PARITY_MAX_W'(sel_row[gi*STORE_W +: LANE_WIDTH]));
`endif
    end

    for (gi = 0; gi < NUM_BANKS; gi++) begin : gen_bank
        ram_bank #(
            .IDX_W  (IDX_W),
            .LANES  (LANES),
            .LANE_W (STORE_W)
        ) u_bank (
            .clk     (clk),
            .en      (bank_en[gi]),
            .we      (bank_we),
            .lane_we (bank_lane_we),
            .addr    (bank_addr),
            .wdata   (bank_wdata),
            .rdata   (bank_rdata[gi])
        );
    end

    assign sel_row = bank_rdata[rd_bank_q];

    // Response data is only trusted in the valid cycle; otherwise replay the hold copy.
    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rsp_valid_q ? sel_data : rdata_hold_q;
    assign rdata_hold_d = rsp_rdata;
`ifdef BANKED_SYNC_RAM_PARITY_EN
    assign parity_err = rsp_valid_q ? sel_perr : '0;
`else
    assign parity_err = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_INIT;
            init_cnt_q   <= '0;
            rsp_valid_q  <= 1'b0;
            rd_bank_q    <= '0;
            rdata_hold_q <= '0;
        end else begin
            state_q      <= state_d;
            init_cnt_q   <= init_cnt_d;
            rsp_valid_q  <= rsp_valid_d;
            rd_bank_q    <= rd_bank_d;
            rdata_hold_q <= rdata_hold_d;
        end
    end

endmodule

// File: tb/tb_banked_sync_ram.sv
// Directed testbench for banked_sync_ram (default geometry: 12-bit address,
// 16-bit data, 2 banks, 8-bit lanes).
module tb_banked_sync_ram;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [11:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic [1:0]  req_lane_en = '0;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        init_done;
    logic [1:0]  parity_err;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    banked_sync_ram dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_lane_en (req_lane_en),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .init_done   (init_done),
        .parity_err  (parity_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        $display("check %-16s observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!req_ready && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(tag, n, 2048);
    endtask

    task automatic do_write(input logic [11:0] a, input logic [15:0] d, input logic [1:0] le);
        @(negedge clk);
        req_valid   = 1'b1;
        req_we      = 1'b1;
        req_addr    = a;
        req_wdata   = d;
        req_lane_en = le;
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = 1'b0;
        $display("write addr=0x%03h data=0x%04h lanes=%b", a, d, le);
    endtask

    // Read issued in cycle N; response checked mid cycle N+1, hold checked in N+2.
    task automatic do_read(input string tag, input logic [11:0] a, input logic [15:0] exp);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = a;
        @(negedge clk);
        req_valid = 1'b0;
        chk({tag, "_vld"}, rsp_valid, 1);
        chk({tag, "_data"}, rsp_rdata, exp);
        chk({tag, "_perr"}, parity_err, 0);
        @(negedge clk);
        chk({tag, "_vld0"}, rsp_valid, 0);
        chk({tag, "_hold"}, rsp_rdata, exp);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", req_ready, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_perr", parity_err, 0);

        rst_n = 1'b1;
        wait_ready("init_cycles");
        chk("init_done", init_done, 1);
        do_read("init_rd0", 12'h000, 16'h0000);

        do_write(12'h005, 16'hABCD, 2'b11);
        do_write(12'h005, 16'h1234, 2'b01);
        chk("wr_no_rsp", rsp_valid, 0);
        do_read("lanes", 12'h005, 16'hAB34);

        do_write(12'h005, 16'hFFFF, 2'b00);
        do_read("noop_wr", 12'h005, 16'hAB34);

        do_write(12'h900, 16'h5A5A, 2'b10);
        do_read("upper_lane", 12'h900, 16'h5A00);

        // Read the cycle right after the write is accepted.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 12'h123;
        req_wdata = 16'hBEEF; req_lane_en = 2'b11;
        @(negedge clk);
        req_we = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        chk("raw_vld", rsp_valid, 1);
        chk("raw_data", rsp_rdata, 16'hBEEF);

        do_write(12'h7FF, 16'h1111, 2'b11);
        do_write(12'h800, 16'h2222, 2'b11);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 12'h7FF;
        @(negedge clk);
        req_addr = 12'h800;
        chk("split_vld_a", rsp_valid, 1);
        chk("split_data_a", rsp_rdata, 16'h1111);
        @(negedge clk);
        req_valid = 1'b0;
        chk("split_vld_b", rsp_valid, 1);
        chk("split_data_b", rsp_rdata, 16'h2222);
        @(negedge clk);
        chk("split_vld_end", rsp_valid, 0);
        chk("split_hold", rsp_rdata, 16'h2222);

        do_write(12'h010, 16'h0300, 2'b11);
`ifdef BANKED_SYNC_RAM_PARITY_EN
        dut.gen_bank[0].u_bank.gen_lane[1].mem_q[16][0] = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 12'h010;
        @(negedge clk);
        req_valid = 1'b0;
        chk("par_vld", rsp_valid, 1);
        chk("par_data", rsp_rdata, 16'h0200);
        chk("par_err", parity_err, 2'b10);
        @(negedge clk);
        chk("par_err_idle", parity_err, 2'b00);
`else
        do_read("par_off", 12'h010, 16'h0300);
`endif

        // Reset lands before the read's acceptance edge: no response may appear.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 12'h005;
        #2;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("rstop_vld", rsp_valid, 0);
        chk("rstop_ready", req_ready, 0);
        @(posedge clk);
        #1;
        chk("rstop_vld2", rsp_valid, 0);
        chk("rstop_rdata", rsp_rdata, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready("reinit_cycles");
        do_read("reinit_005", 12'h005, 16'h0000);
        do_read("reinit_7ff", 12'h7FF, 16'h0000);
        do_read("reinit_800", 12'h800, 16'h0000);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
